// File: rtl/interrupt_pkg.sv
// Shared definitions for the interrupt controller and the interrupt entry sequencer.
package interrupt_pkg;

    localparam logic [11:0] IRQ_NONE = 12'o7777;
    localparam int DEFAULT_INTERRUPT_LINES = 24;

    typedef enum logic [1:0] {
        IDLE,
        DISMISS,
        SAVE,
        JUMP
    } seq_state_t;

endpackage

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: accepts a pending interrupt at an instruction boundary,
// dismisses it in the controller, pushes the return PC and issues the vector jump.
module interrupt_sequencer
    import interrupt_pkg::*;
#(
    parameter int          INTERRUPT_LINES = DEFAULT_INTERRUPT_LINES,
    parameter logic [11:0] VECTOR_BASE     = 12'o0100,
    parameter int          VECTOR_STRIDE   = 2,
    parameter logic [11:0] SOFT_VECTOR     = 12'o0070
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] next_interrupt,
    input  logic        insn_boundary,
    input  logic [11:0] pc,
    input  logic        ien_set,
    input  logic        ien_clr,
    input  logic        iret,
    input  logic        cpu_cmd_valid,
    input  logic        cpu_create,
    input  logic        cpu_dismiss,
    input  logic [11:0] cpu_cmd_data,
    output logic        cpu_cmd_ready,
    output logic        take,
    output logic        cpu_hold,
    output logic        save_we,
    output logic [11:0] save_data,
    output logic        vector_valid,
    output logic [11:0] vector_addr,
    output logic [11:0] cause,
    output logic        ien,
    output logic        ctl_dismiss,
    output logic        ctl_create,
    output logic [11:0] ctl_data,
    output seq_state_t  dbg_state
);

    localparam logic [11:0] LINES  = 12'(INTERRUPT_LINES);
    localparam logic [11:0] STRIDE = 12'(VECTOR_STRIDE);

    seq_state_t  state;
    logic        ien_block;
    logic        dismiss_q;
    logic [11:0] pc_q;

    // ien_block suppresses acceptance for exactly one cycle after re-enable,
    // so the instruction following ien_set/iret always executes.
    assign take = (state == IDLE) & insn_boundary & ien & (next_interrupt != IRQ_NONE)
                  & ~ien_clr & ~ien_block;

    assign cpu_cmd_ready = (state == IDLE);
    assign save_data     = pc_q;
    assign dbg_state     = state;
    assign vector_addr   = (cause < LINES) ? (VECTOR_BASE + cause * STRIDE) : SOFT_VECTOR;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            ien          <= 1'b0;
            ien_block    <= 1'b0;
            cause        <= IRQ_NONE;
            pc_q         <= 12'd0;
            cpu_hold     <= 1'b0;
            save_we      <= 1'b0;
            vector_valid <= 1'b0;
            dismiss_q    <= 1'b0;
        end else begin
            // Priority on the enable flag: clear, then entry, then set/iret.
            ien_block <= 1'b0;
            if (ien_clr) begin
                ien <= 1'b0;
            end else if (take) begin
                ien <= 1'b0;
            end else if (ien_set || iret) begin
                ien       <= 1'b1;
                ien_block <= 1'b1;
            end

            cpu_hold     <= 1'b0;
            save_we      <= 1'b0;
            vector_valid <= 1'b0;
            dismiss_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        cause     <= next_interrupt;
                        pc_q      <= pc;
                        state     <= DISMISS;
                        cpu_hold  <= 1'b1;
                        dismiss_q <= 1'b1;
                    end
                end
                DISMISS: begin
                    state    <= SAVE;
                    cpu_hold <= 1'b1;
                    save_we  <= 1'b1;
                end
                SAVE: begin
                    state        <= JUMP;
                    cpu_hold     <= 1'b1;
                    vector_valid <= 1'b1;
                end
                JUMP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The CPU owns the controller bus in IDLE; otherwise the sequencer does.
    always_comb begin
        ctl_dismiss = 1'b0;
        ctl_create  = 1'b0;
        ctl_data    = 12'd0;
        if (state == IDLE) begin
            ctl_dismiss = cpu_cmd_valid & cpu_dismiss;
            ctl_create  = cpu_cmd_valid & cpu_create;
            ctl_data    = cpu_cmd_valid ? cpu_cmd_data : 12'd0;
        end else begin
            ctl_dismiss = dismiss_q;
            ctl_data    = cause;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: directed entry scenarios plus random traffic
// compared every cycle against a cycle-count based model of the entry sequence.
module tb_interrupt_sequencer;
    import interrupt_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] next_interrupt = IRQ_NONE;
    logic        insn_boundary = 1'b0;
    logic [11:0] pc = 12'd0;
    logic        ien_set = 1'b0, ien_clr = 1'b0, iret = 1'b0;
    logic        cpu_cmd_valid = 1'b0, cpu_create = 1'b0, cpu_dismiss = 1'b0;
    logic [11:0] cpu_cmd_data = 12'd0;

    logic        cpu_cmd_ready, take, cpu_hold, save_we, vector_valid, ien;
    logic        ctl_dismiss, ctl_create;
    logic [11:0] save_data, vector_addr, cause, ctl_data;
    seq_state_t  dbg_state;

    logic        w_ready, w_take, w_hold, w_save_we, w_vv, w_ien, w_dis, w_cre;
    logic [11:0] w_save_data, w_vector, w_cause, w_ctl_data;
    seq_state_t  w_state;

    always #5 clk = ~clk;

    interrupt_sequencer dut (
        .clk(clk), .rst(rst), .next_interrupt(next_interrupt), .insn_boundary(insn_boundary),
        .pc(pc), .ien_set(ien_set), .ien_clr(ien_clr), .iret(iret),
        .cpu_cmd_valid(cpu_cmd_valid), .cpu_create(cpu_create), .cpu_dismiss(cpu_dismiss),
        .cpu_cmd_data(cpu_cmd_data), .cpu_cmd_ready(cpu_cmd_ready), .take(take),
        .cpu_hold(cpu_hold), .save_we(save_we), .save_data(save_data),
        .vector_valid(vector_valid), .vector_addr(vector_addr), .cause(cause), .ien(ien),
        .ctl_dismiss(ctl_dismiss), .ctl_create(ctl_create), .ctl_data(ctl_data),
        .dbg_state(dbg_state)
    );

    // Second instance with a vector base near the top of memory, to exercise wrap-around.
    interrupt_sequencer #(.VECTOR_BASE(12'o7776)) dut_wrap (
        .clk(clk), .rst(rst), .next_interrupt(next_interrupt), .insn_boundary(insn_boundary),
        .pc(pc), .ien_set(ien_set), .ien_clr(ien_clr), .iret(iret),
        .cpu_cmd_valid(cpu_cmd_valid), .cpu_create(cpu_create), .cpu_dismiss(cpu_dismiss),
        .cpu_cmd_data(cpu_cmd_data), .cpu_cmd_ready(w_ready), .take(w_take),
        .cpu_hold(w_hold), .save_we(w_save_we), .save_data(w_save_data),
        .vector_valid(w_vv), .vector_addr(w_vector), .cause(w_cause), .ien(w_ien),
        .ctl_dismiss(w_dis), .ctl_create(w_cre), .ctl_data(w_ctl_data),
        .dbg_state(w_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: the sequence is tracked only as "cycles since the last accepted interrupt".
    logic        m_ien = 1'b0;
    int          m_block_cyc = -100;
    int          m_take_cyc = -100;
    logic [11:0] m_cause = IRQ_NONE;
    logic [11:0] m_pc = 12'd0;

    function automatic logic [11:0] vec_of(input logic [11:0] c, input int base);
        if (int'(c) < 24) return 12'((base + int'(c) * 2) % 4096);
        return 12'o0070;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0o, expected %0o", name, cyc, act, exp);
        end
    endtask

    task automatic clear_inputs();
        next_interrupt = IRQ_NONE;
        insn_boundary  = 1'b0;
        pc             = 12'd0;
        ien_set        = 1'b0;
        ien_clr        = 1'b0;
        iret           = 1'b0;
        cpu_cmd_valid  = 1'b0;
        cpu_create     = 1'b0;
        cpu_dismiss    = 1'b0;
        cpu_cmd_data   = 12'd0;
    endtask

    // Called with inputs set just after a falling edge; compares, then advances one cycle.
    task automatic tick();
        int   since;
        logic busy, exp_take, exp_dis, exp_cre;
        #1;
        since    = cyc - m_take_cyc;
        busy     = (since >= 1) && (since <= 3);
        exp_take = !busy && insn_boundary && m_ien && (next_interrupt != IRQ_NONE)
                   && !ien_clr && (cyc != m_block_cyc);
        exp_dis  = busy ? (since == 1) : (cpu_cmd_valid && cpu_dismiss);
        exp_cre  = busy ? 1'b0 : (cpu_cmd_valid && cpu_create);

        chk("take", 12'(take), 12'(exp_take));
        chk("cpu_hold", 12'(cpu_hold), 12'(busy));
        chk("cpu_cmd_ready", 12'(cpu_cmd_ready), 12'(!busy));
        chk("save_we", 12'(save_we), 12'(since == 2));
        chk("vector_valid", 12'(vector_valid), 12'(since == 3));
        chk("ien", 12'(ien), 12'(m_ien));
        chk("cause", cause, m_cause);
        chk("vector_addr", vector_addr, vec_of(m_cause, 'o0100));
        chk("ctl_dismiss", 12'(ctl_dismiss), 12'(exp_dis));
        chk("ctl_create", 12'(ctl_create), 12'(exp_cre));
        if (!busy) chk("ctl_data_cpu", ctl_data, cpu_cmd_valid ? cpu_cmd_data : 12'd0);
        if (since == 1) chk("ctl_data_dismiss", ctl_data, m_cause);
        if (since == 2) chk("save_data", save_data, m_pc);
        chk("dbg_state_idle", 12'(dbg_state == IDLE), 12'(!busy));
        chk("wrap_take", 12'(w_take), 12'(exp_take));
        chk("wrap_vector_addr", w_vector, vec_of(m_cause, 'o7776));
        chk("wrap_state_idle", 12'(w_state == IDLE), 12'(!busy));

        @(posedge clk);
        if (!rst) begin
            m_ien       = 1'b0;
            m_block_cyc = -100;
            m_take_cyc  = -100;
            m_cause     = IRQ_NONE;
            m_pc        = 12'd0;
        end else begin
            if (exp_take) begin
                m_take_cyc = cyc;
                m_cause    = next_interrupt;
                m_pc       = pc;
            end
            if (ien_clr || exp_take) begin
                m_ien = 1'b0;
            end else if (ien_set || iret) begin
                m_ien       = 1'b1;
                m_block_cyc = cyc + 1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            clear_inputs();
            tick();
        end
    endtask

    // Re-enable, then one spare cycle so the block window has passed.
    task automatic enable_ints();
        clear_inputs();
        ien_set = 1'b1;
        tick();
        idle_cycles(1);
    endtask

    task automatic boundary_with(input logic [11:0] code, input logic [11:0] ret_pc);
        clear_inputs();
        insn_boundary  = 1'b1;
        next_interrupt = code;
        pc             = ret_pc;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        // Reset state (rst still low for this compared cycle)
        chk("reset_cause", cause, 12'o7777);
        chk("reset_vector", vector_addr, 12'o0070);
        chk("reset_ien", 12'(ien), 12'd0);
        chk("reset_hold", 12'(cpu_hold), 12'd0);
        tick();
        rst = 1'b1;
        idle_cycles(2);

        // ien_set at N, boundary at N+1 blocked, take at N+2: line 2, pc 0o1234
        clear_inputs();
        ien_set = 1'b1;
        tick();
        boundary_with(12'd0, 12'o0777);
        #1 chk("blocked_take", 12'(take), 12'd0);
        tick();
        boundary_with(12'd2, 12'o1234);
        #1 chk("line2_take", 12'(take), 12'd1);
        tick();
        clear_inputs();
        chk("line2_dismiss", 12'(ctl_dismiss), 12'd1);
        chk("line2_ctl_data", ctl_data, 12'd2);
        chk("line2_ien", 12'(ien), 12'd0);
        tick();
        chk("line2_save_we", 12'(save_we), 12'd1);
        chk("line2_save_data", save_data, 12'o1234);
        tick();
        chk("line2_vector_valid", 12'(vector_valid), 12'd1);
        chk("line2_vector", vector_addr, 12'o0104);
        chk("line2_wrap_vector", w_vector, 12'o0002);
        tick();
        chk("line2_done_hold", 12'(cpu_hold), 12'd0);

        // Software code 0o7000 via iret
        clear_inputs();
        iret = 1'b1;
        tick();
        idle_cycles(1);
        boundary_with(12'o7000, 12'o0500);
        tick();
        clear_inputs();
        chk("soft_ctl_data", ctl_data, 12'o7000);
        idle_cycles(2);
        chk("soft_vector", vector_addr, 12'o0070);
        chk("soft_cause", cause, 12'o7000);
        idle_cycles(1);

        // Line 3 with a CPU create command issued during SAVE
        enable_ints();
        boundary_with(12'd3, 12'o2000);
        tick();
        idle_cycles(1);
        clear_inputs();
        cpu_cmd_valid = 1'b1;
        cpu_create    = 1'b1;
        cpu_cmd_data  = 12'o7001;
        #1 chk("cmd_stall_save", 12'(cpu_cmd_ready), 12'd0);
        chk("cmd_no_create_save", 12'(ctl_create), 12'd0);
        tick();
        #1 chk("cmd_stall_jump", 12'(cpu_cmd_ready), 12'd0);
        chk("line3_vector", vector_addr, 12'o0106);
        chk("line3_wrap_vector", w_vector, 12'o0004);
        tick();
        #1 chk("cmd_ready_idle", 12'(cpu_cmd_ready), 12'd1);
        chk("cmd_create_idle", 12'(ctl_create), 12'd1);
        chk("cmd_data_idle", ctl_data, 12'o7001);
        tick();
        idle_cycles(1);

        // Reset asserted at T+2 aborts the sequence
        enable_ints();
        boundary_with(12'd5, 12'o0321);
        tick();
        idle_cycles(1);
        clear_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_vector_valid", 12'(vector_valid), 12'd0);
        chk("abort_ien", 12'(ien), 12'd0);
        chk("abort_cause", cause, 12'o7777);
        chk("abort_idle", 12'(dbg_state == IDLE), 12'd1);
        idle_cycles(2);

        // ien_clr in the same cycle as otherwise valid take conditions
        enable_ints();
        boundary_with(12'd1, 12'o0100);
        ien_clr = 1'b1;
        #1 chk("clr_blocks_take", 12'(take), 12'd0);
        tick();
        idle_cycles(1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            clear_inputs();
            insn_boundary = ($urandom_range(0, 1) == 1);
            pc            = 12'($urandom_range(0, 4095));
            case ($urandom_range(0, 7))
                0, 1:    next_interrupt = IRQ_NONE;
                2:       next_interrupt = 12'($urandom_range(0, 4095));
                3:       next_interrupt = 12'($urandom_range(24, 40));
                default: next_interrupt = 12'($urandom_range(0, 23));
            endcase
            ien_set       = ($urandom_range(0, 7) == 0);
            iret          = ($urandom_range(0, 15) == 0);
            ien_clr       = ($urandom_range(0, 15) == 0);
            cpu_cmd_valid = ($urandom_range(0, 3) == 0);
            cpu_create    = ($urandom_range(0, 1) == 1);
            cpu_dismiss   = ($urandom_range(0, 1) == 1);
            cpu_cmd_data  = 12'($urandom_range(0, 4095));
            rst           = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst = 1'b1;
        idle_cycles(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Interrupt entry sequencer between the interrupt controller and the CPU core. It watches the controller's `next_interrupt` code and a CPU-owned interrupt-enable flag. At an instruction boundary it accepts the pending interrupt, dismisses it in the controller, hands the return PC to the CPU for saving, and issues a vector jump. It also owns the controller's `dismiss`/`create`/`data_in` bus, arbitrating CPU software-interrupt commands against its own acknowledge cycles.

## Interface
- `INTERRUPT_LINES`, 24: hardware lines in the controller; codes below this are hardware.
- `VECTOR_BASE`, 12'o0100: vector of hardware line 0.
- `VECTOR_STRIDE`, 2: words between hardware vectors.
- `SOFT_VECTOR`, 12'o0070: single vector for every software code.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous and active-low.
- `next_interrupt` in 12: controller output; 12'o7777 means none pending.
- `insn_boundary` in 1: CPU is at an instruction fetch boundary this cycle.
- `pc` in 12: return address valid when `insn_boundary`=1.
- `ien_set`, `ien_clr`, `iret` in 1 each: CPU enable controls.
- `cpu_cmd_valid`, `cpu_create`, `cpu_dismiss` in 1 each; `cpu_cmd_data` in 12: CPU controller command.
- `cpu_cmd_ready` out 1: command accepted this cycle.
- `take` out 1: combinational; interrupt accepted at this boundary, so the CPU must not fetch.
- `cpu_hold` out 1: CPU stalled.
- `save_we` out 1; `save_data` out 12: push return PC.
- `vector_valid` out 1; `vector_addr` out 12: load PC.
- `cause` out 12: latched code of the last accepted interrupt.
- `ien` out 1: interrupt enable.
- `ctl_dismiss`, `ctl_create` out 1 each; `ctl_data` out 12: to controller.

## Operation
- States:
  - IDLE: wait for an acceptable interrupt.
  - DISMISS: drive `ctl_dismiss`=1 and `ctl_data`=`cause`.
  - SAVE: drive `save_we`=1 and `save_data`=latched PC.
  - JUMP: drive `vector_valid`=1.
- `take` = IDLE & `insn_boundary` & `ien` & (`next_interrupt`≠7777) & ~`ien_clr` & ~`ien_block`.
- On `take`:
  - latch `cause`←`next_interrupt` and the PC;
  - clear `ien`;
  - go to DISMISS.
- Transitions: DISMISS→SAVE→JUMP→IDLE, unconditionally.
- Vector:
  - if `cause` < `INTERRUPT_LINES`: `vector_addr` = `VECTOR_BASE` + `cause`·`VECTOR_STRIDE`, truncated to 12 bits (wraps mod 4096);
  - otherwise: `SOFT_VECTOR`.
- Enable flag:
  - `ien_clr` beats `ien_set`;
  - `ien_set` or `iret` sets `ien` next cycle and sets a one-cycle `ien_block`, so no interrupt is taken on the boundary immediately following. This guarantees one instruction executes after re-enable.
  - `iret` and `ien_set` outside IDLE are still applied.
- CPU command path:
  - `cpu_cmd_ready` = (state==IDLE).
  - In IDLE, `ctl_dismiss`/`ctl_create`/`ctl_data` pass through from the CPU command, gated by `cpu_cmd_valid`.
  - In non-IDLE states the CPU command is stalled and the sequencer drives the bus (create=0 except as stated).
  - A command and `take` in the same IDLE cycle are both honoured: the command goes out that cycle, the dismiss goes out the next.
- Reset (rst=0 at a clk edge, any state):
  - state=IDLE, `ien`=0, `ien_block`=0, `cause`=7777, latched PC=0;
  - all registered outputs 0;
  - `vector_addr` = `SOFT_VECTOR` decode of 7777.

## Timing
- `take` is seen at cycle T (combinational), with `cpu_hold`=1 in T+1..T+3:
  - T+1: `ctl_dismiss`=1. The controller clears the source at the T+2 edge.
  - T+2: `save_we`=1.
  - T+3: `vector_valid`=1. The CPU loads the PC at the T+4 edge and fetches.
- Total latency from accept to first vector fetch is 4 cycles.
- Back-to-back interrupts are impossible without `ien_set`/`iret`, since `ien` clears on entry.
- `next_interrupt` changes after T are ignored; `cause` is stable until the next `take`.
- Reset asserted mid-sequence aborts with no further `save_we`/`vector_valid`. The controller is not dismissed if the abort happens before T+1.

## Structure
- Shared `interrupt_pkg`:
  - `IRQ_NONE` = 12'o7777;
  - state enum {IDLE, DISMISS, SAVE, JUMP};
  - `INTERRUPT_LINES` default.
  - The controller already uses the 7777 convention; both blocks import it.
- Single module. No sub-module is warranted; vector computation is one inline expression.

## Test plan
- Hardware line 2 pending, `ien`=1, boundary with pc=0o1234 → `take` at T; dismiss with data 2 at T+1; save 0o1234 at T+2; vector 0o0104 at T+3; `ien`=0.
- Software code 0o7000 only, boundary → dismiss with data 0o7000; vector 0o0070; `cause`=0o7000.
- `ien_set` at cycle N, boundary at N+1 with line 0 pending → no `take` at N+1; `take` at the next boundary N+k.
- `cpu_cmd_valid`, `cpu_create`, data 0o7001 issued during SAVE → `cpu_cmd_ready`=0 until IDLE; the create reaches the controller the first IDLE cycle.
- `VECTOR_BASE`=0o7776, line 3 → `vector_addr`=0o0004 (wrap).
- rst low at T+2 → next cycle IDLE, `ien`=0, `cause`=7777, no `vector_valid`; `ien_clr` plus `take` conditions in the same cycle → no `take`.
